// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, wait-state ceiling, default word width and the address-check helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned WAIT_MAX           = 15;
    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    // Misaligned byte address, or word index beyond the array depth.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_width);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= (32'd1 << addr_width));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-memory load/store handshake bundle.
// Carries the byte-enable lane bus only when DMEM_BYTE_LANE_EN is defined.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

    logic                  req;
    logic                  we;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
`ifdef DMEM_BYTE_LANE_EN
    logic [DATA_WIDTH/8-1:0] be;
`endif
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;
    logic                  busy;

`ifdef DMEM_BYTE_LANE_EN
    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata, error, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata, error, busy
    );
`else
    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, error, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, error, busy
    );
`endif

endinterface

// File: rtl/dmem_ram.sv
// Word-addressed storage: synchronous write, combinational read, no reset.
// With DMEM_BYTE_LANE_EN defined, writes honour per-byte lane enables.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef DMEM_BYTE_LANE_EN
    input  logic [DATA_WIDTH/8-1:0] be,
`endif
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
`ifdef DMEM_BYTE_LANE_EN
            for (int i = 0; i < int'(DATA_WIDTH / 8); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
`else
            mem[addr] <= wdata;
`endif
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency responder for the core's data-memory port: accept, wait, one-cycle response.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_LANE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    if (WAIT_STATES > WAIT_MAX) begin : g_wait_check
        $error("WAIT_STATES exceeds WAIT_MAX");
    end

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef DMEM_BYTE_LANE_EN
    logic [DATA_WIDTH/8-1:0] be_q;
    logic [DATA_WIDTH/8-1:0] acc_be;
`endif

    logic                    ready_q;
    logic                    error_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    bus_err;
    logic                    in_idle;
    logic                    acc_fire;
    logic                    acc_we;
    logic                    acc_err;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic [DATA_WIDTH-1:0]   resp_rdata;

    assign bus_err = addr_bad(bus.addr, ADDR_WIDTH);

    // With zero wait states the access happens on the accept edge, so the array
    // sees the live bus; otherwise it sees the values captured at accept.
    always_comb begin
        in_idle   = (state_q == StIdle);
        acc_we    = in_idle ? bus.we : we_q;
        acc_err   = in_idle ? bus_err : err_q;
        acc_idx   = in_idle ? bus.addr[ADDR_WIDTH+1:2] : idx_q;
        acc_wdata = in_idle ? bus.wdata : wdata_q;
`ifdef DMEM_BYTE_LANE_EN
        acc_be    = in_idle ? bus.be : be_q;
`endif
        if (in_idle) begin
            acc_fire = bus.req && (WAIT_STATES == 0);
        end else begin
            acc_fire = (state_q == StWait) && (cnt_q == 4'd1);
        end
    end

    assign ram_we     = acc_fire && acc_we && !acc_err;
    assign resp_rdata = (acc_we || acc_err) ? '0 : ram_rdata;

    dmem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (acc_idx),
        .wdata (acc_wdata),
`ifdef DMEM_BYTE_LANE_EN
        .be    (acc_be),
`endif
        .rdata (ram_rdata)
    );

    // Errors take the same path through WAIT as good accesses so that the
    // response latency is independent of the address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef DMEM_BYTE_LANE_EN
            be_q    <= '0;
`endif
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            if (acc_fire) begin
                ready_q <= 1'b1;
                error_q <= acc_err;
                rdata_q <= resp_rdata;
            end

            case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        err_q   <= bus_err;
                        idx_q   <= bus.addr[ADDR_WIDTH+1:2];
                        wdata_q <= bus.wdata;
`ifdef DMEM_BYTE_LANE_EN
                        be_q    <= bus.be;
`endif
                        busy_q  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_q <= StResp;
                        end else begin
                            cnt_q   <= WAIT_LOAD;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.error = error_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none.
// Byte-lane cases are included when DMEM_BYTE_LANE_EN is defined.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   rdy0_count = 0;
    exp_t q2[$];
    exp_t q0[$];

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .WAIT_STATES (2)
    ) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_responder #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .WAIT_STATES (0)
    ) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus2.ready) begin
            if (q2.size() == 0) begin
                check("ws2_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("ws2_rdata", bus2.rdata, e.rdata);
                check("ws2_error", 32'(bus2.error), 32'(e.err));
                check("ws2_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus0.ready) begin
            rdy0_count++;
            if (q0.size() == 0) begin
                check("ws0_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("ws0_rdata", bus0.rdata, e.rdata);
                check("ws0_error", 32'(bus0.error), 32'(e.err));
                check("ws0_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One request; response checked by the monitor, busy checked here.
    task automatic txn(input bit ws0, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        exp_t e;
        bit   seen;
        @(negedge clock);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + (ws0 ? 1 : 3);
        if (ws0) begin
            bus0.req = 1'b1; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata;
`ifdef DMEM_BYTE_LANE_EN
            bus0.be = be;
`endif
            q0.push_back(e);
        end else begin
            bus2.req = 1'b1; bus2.we = we; bus2.addr = addr; bus2.wdata = wdata;
`ifdef DMEM_BYTE_LANE_EN
            bus2.be = be;
`endif
            q2.push_back(e);
        end
        @(negedge clock);
        bus0.req = 1'b0;
        bus2.req = 1'b0;
        check({tag, "_busy"}, 32'(ws0 ? bus0.busy : bus2.busy), 32'd1);
        seen = ws0 ? bus0.ready : bus2.ready;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = ws0 ? bus0.ready : bus2.ready;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clock);
        check({tag, "_idle"}, 32'(ws0 ? bus0.busy : bus2.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
`ifdef DMEM_BYTE_LANE_EN
        bus2.be = 4'hF;
        bus0.be = 4'hF;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(bus2.ready), 32'd0);
        check("rst_error", 32'(bus2.error), 32'd0);
        check("rst_busy", 32'(bus2.busy), 32'd0);
        check("rst_rdata", bus2.rdata, 32'd0);
        check("rst_busy0", 32'(bus0.busy), 32'd0);
        reset = 1'b0;

        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st_10");
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, "ld_10");
        txn(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, "st_0");
        txn(1'b0, 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1, "ld_misaligned");
        txn(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "st_misaligned");
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, "ld_10_again");
        txn(1'b0, 1'b1, 32'h400, 32'h55555555, 4'hF, 32'h0, 1'b1, "st_oor");
        txn(1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 32'h0, 1'b1, "ld_oor");
        txn(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, "ld_0");

        // Reset during WAIT must abort the store before it commits.
        txn(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0, "st_20");
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11111111, 1'b0, "ld_20");
        @(negedge clock);
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h20; bus2.wdata = 32'h12345678;
        @(negedge clock);
        bus2.req = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(bus2.ready), 32'd0);
        check("midrst_error", 32'(bus2.error), 32'd0);
        check("midrst_busy", 32'(bus2.busy), 32'd0);
        check("midrst_rdata", bus2.rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("midrst_noresp", 32'(q2.size()), 32'd0);
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11111111, 1'b0, "ld_20_after_rst");

`ifdef DMEM_BYTE_LANE_EN
        txn(1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0, "be_st_full");
        txn(1'b0, 1'b1, 32'h8, 32'h00001100, 4'b0010, 32'h0, 1'b0, "be_st_lane1");
        txn(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 32'hAABB11DD, 1'b0, "be_ld_lane1");
        txn(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "be_st_none");
        txn(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hAABB11DD, 1'b0, "be_ld_none");
`endif

        for (int k = 0; k < 4; k++) begin
            txn(1'b1, 1'b1, 32'(k * 4), 32'hC0DE0000 + 32'(k), 4'hF, 32'h0, 1'b0, "ws0_st");
        end

        // Held req: accepts only in IDLE; a bad address shown during RESP must be ignored.
        rdy0_count = 0;
        @(negedge clock);
        bus0.req = 1'b1;
        bus0.we  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus0.addr = 32'(k * 4);
            e.rdata = 32'hC0DE0000 + 32'(k);
            e.err   = 1'b0;
            e.cyc   = cyc + 1;
            q0.push_back(e);
            @(negedge clock);
            bus0.addr = 32'h3;
            @(negedge clock);
        end
        bus0.req = 1'b0;
        repeat (4) @(negedge clock);
        check("held_count", 32'(rdy0_count), 32'd4);
        check("held_q0_empty", 32'(q0.size()), 32'd0);
        check("q2_empty", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
